bus_decode_wait_ctrl: RTL and testbench

//  Parametrised 8088 bus-side address latch, chip-select decoder and READY wait-state generator.

---
 rtl/bus_decode_pkg.sv | 19 +
 rtl/bus_wait_timer.sv | 26 ++
 rtl/bus_decode_wait_ctrl.sv | 134 +++++++++++++
 tb/tb_bus_decode_wait_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/bus_decode_pkg.sv
// bus_decode_pkg: shared state encoding, limits and region match helper for the 8088 bus decoder.
package bus_decode_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} bus_state_e;

    localparam int MAX_REGIONS = 8;
    localparam int WAIT_W      = 4;

    function automatic logic region_hit(
        input logic [31:0] addr,
        input logic        iom,
        input logic [31:0] base,
        input logic [31:0] mask,
        input logic        riom
    );
        return (iom == riom) && ((addr & mask) == base);
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// bus_wait_timer: loadable down-counter that saturates at zero; expire flags the last counted cycle.
module bus_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         abort_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d = load_i ? load_val_i :
                   abort_i ? '0 :
                   (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign expire_o = cnt_q == W'(1);

endmodule

// File: rtl/bus_decode_wait_ctrl.sv
// bus_decode_wait_ctrl: 8088 ALE address latch, priority chip-select decoder and READY wait-state generator.
// Define BUS_TIMEOUT_EN to time out unmapped accesses and pulse BUS_ERR.
module bus_decode_wait_ctrl
    import bus_decode_pkg::*;
#(
    parameter int                                NUM_REGIONS  = 4,
    parameter int                                ADDR_WIDTH   = 20,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE  = '0,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK  = '0,
    parameter logic [NUM_REGIONS-1:0]            REGION_IOM   = '0,
    parameter logic [NUM_REGIONS*WAIT_W-1:0]     REGION_WAITS = '0,
    parameter int                                TIMEOUT_CYC  = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ALE,
    input  logic                  IOM,
    input  logic                  RD,
    input  logic                  WR,
    input  logic [ADDR_WIDTH-9:0] A,
    input  logic [7:0]            AD,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [NUM_REGIONS-1:0] CS,
    output logic                  READY,
    output logic                  BUS_ERR
);

    if (NUM_REGIONS < 1 || NUM_REGIONS > MAX_REGIONS) $error("NUM_REGIONS out of range");
    if (TIMEOUT_CYC < 1) $error("TIMEOUT_CYC must be at least 1");

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = TW > WAIT_W ? TW : WAIT_W;
`else
    localparam int CW = WAIT_W;
`endif

    bus_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  iom_q, vld_q, ready_q;
    logic [NUM_REGIONS-1:0] cs;
    logic [WAIT_W-1:0]     hit_waits;
    logic [CW-1:0]         load_val;
    logic                  access, load, abort, expire;

    assign access = !RD || !WR;

    // Iterate high to low so the lowest-index matching region overwrites the rest.
    // vld_q keeps CS low between reset and the first latched address.
    always_comb begin
        cs = '0;
        hit_waits = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if (vld_q && region_hit(32'(addr_q), iom_q, 32'(REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]),
                                    32'(REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]), REGION_IOM[i])) begin
                cs = '0;
                cs[i] = 1'b1;
                hit_waits = REGION_WAITS[i*WAIT_W +: WAIT_W];
            end
    end

`ifdef BUS_TIMEOUT_EN
    assign load_val = |cs ? CW'(hit_waits) : CW'(TIMEOUT_CYC);
`else
    assign load_val = CW'(hit_waits);
`endif

    always_comb begin
        state_d = state_q;
        load = 1'b0;
        abort = 1'b0;
        if (ALE) begin
            state_d = ADDR;
            abort = 1'b1;
        end else
            case (state_q)
                ADDR: if (access) begin
                    state_d = load_val == '0 ? DONE : WAIT;
                    load = load_val != '0;
                end
                WAIT: if (!access) begin
                    state_d = IDLE;
                    abort = 1'b1;
                end else if (expire) state_d = DONE;
                DONE: if (!access) state_d = IDLE;
                default: ;
            endcase
    end

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            addr_q <= '0;
            iom_q <= 1'b0;
            vld_q <= 1'b0;
            state_q <= IDLE;
            ready_q <= 1'b1;
        end else begin
            if (ALE) begin
                addr_q <= {A, AD};
                iom_q <= IOM;
                vld_q <= 1'b1;
            end
            state_q <= state_d;
            ready_q <= state_d != WAIT;
        end

    bus_wait_timer #(.W(CW)) u_timer (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (load),
        .abort_i    (abort),
        .en_i       (state_q == WAIT),
        .load_val_i (load_val),
        .expire_o   (expire)
    );

`ifdef BUS_TIMEOUT_EN
    logic err_q;

    // The only WAIT->DONE path is expiry, so with no chip select it must be a timeout.
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) err_q <= 1'b0;
        else       err_q <= state_q == WAIT && state_d == DONE && ~|cs;

    assign BUS_ERR = err_q;
`else
    assign BUS_ERR = 1'b0;
`endif

    assign Address = addr_q;
    assign CS = cs;
    assign READY = ready_q;

endmodule

// File: tb/tb_bus_decode_wait_ctrl.sv
// tb_bus_decode_wait_ctrl: directed bus cycles with a scoreboard monitor for decode, READY waits and BUS_ERR.
module tb_bus_decode_wait_ctrl;

`ifdef BUS_TIMEOUT_EN
    localparam int   TO_N = 16;
    localparam logic TO_ERR = 1'b1;
    localparam int   EXP_ERRS = 2;
`else
    localparam int   TO_N = 0;
    localparam logic TO_ERR = 1'b0;
    localparam int   EXP_ERRS = 0;
`endif

    logic        CLK = 1'b0, RESET = 1'b1, ALE = 1'b0, IOM = 1'b0, RD = 1'b1, WR = 1'b1;
    logic [11:0] A = '0;
    logic [7:0]  AD = '0;
    logic [19:0] Address;
    logic [3:0]  CS;
    logic        READY, BUS_ERR;

    typedef struct {string nm; logic [19:0] addr; logic [3:0] cs; logic ready;} snap_t;
    typedef struct {string nm; int n; logic err;} wait_t;

    snap_t sq[$];
    wait_t wq[$];
    snap_t s;
    wait_t w;
    logic  chk = 1'b0, fin = 1'b0;
    int    tests = 0, fails = 0, low = 0, errs = 0;

    always #5 CLK = ~CLK;

    bus_decode_wait_ctrl #(
        .NUM_REGIONS  (4),
        .ADDR_WIDTH   (20),
        .REGION_BASE  ({20'h01C00, 20'h0FF00, 20'h80000, 20'h00000}),
        .REGION_MASK  ({20'hFFE00, 20'hFFFF0, 20'h80000, 20'h80000}),
        .REGION_IOM   (4'b1100),
        .REGION_WAITS (16'hF120),
        .TIMEOUT_CYC  (16)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ALE     (ALE),
        .IOM     (IOM),
        .RD      (RD),
        .WR      (WR),
        .A       (A),
        .AD      (AD),
        .Address (Address),
        .CS      (CS),
        .READY   (READY),
        .BUS_ERR (BUS_ERR)
    );

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK or posedge chk or posedge fin) begin
        if (chk) begin
            s = sq.pop_front();
            cmp({s.nm, ".addr"}, 32'(Address), 32'(s.addr));
            cmp({s.nm, ".cs"}, 32'(CS), 32'(s.cs));
            cmp({s.nm, ".ready"}, 32'(READY), 32'(s.ready));
            cmp({s.nm, ".bus_err"}, 32'(BUS_ERR), 32'(0));
        end else if (fin) begin
            cmp("bus_err_pulses", errs, EXP_ERRS);
            cmp("waits_pending", wq.size(), 0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
        end else if (RESET) low = 0;
        else begin
            if (BUS_ERR) errs++;
            if (!READY) low++;
            else if (low > 0) begin
                if (wq.size() == 0) cmp("unexpected_wait", low, 0);
                else begin
                    w = wq.pop_front();
                    cmp({w.nm, ".waits"}, low, w.n);
                    cmp({w.nm, ".bus_err"}, 32'(BUS_ERR), 32'(w.err));
                end
                low = 0;
            end
        end
    end

    task automatic snap(string nm, logic [19:0] a, logic [3:0] c, logic r);
        sq.push_back('{nm, a, c, r});
        chk = 1'b1;
        #1 chk = 1'b0;
    endtask

    task automatic bus_cycle(string nm, logic [19:0] adr, logic io, logic rd,
                             logic [3:0] exp_cs, int n, logic err);
        ALE = 1'b1; IOM = io; A = adr[19:8]; AD = adr[7:0];
        @(posedge CLK); #1;
        ALE = 1'b0; AD = 8'hA5;
        if (rd) RD = 1'b0; else WR = 1'b0;
        snap({nm, ".addr_phase"}, adr, exp_cs, 1'b1);
        if (n > 0) wq.push_back('{nm, n, err});
        repeat (n + 2) @(posedge CLK);
        #1 snap({nm, ".done"}, adr, exp_cs, 1'b1);
        RD = 1'b1; WR = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        @(posedge CLK); #1;
        snap("reset", 20'h0, 4'b0000, 1'b1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        bus_cycle("r0_mem_rd", 20'h12345, 1'b0, 1'b1, 4'b0001, 0, 1'b0);
        bus_cycle("r1_mem_rd", 20'h80010, 1'b0, 1'b1, 4'b0010, 2, 1'b0);
        bus_cycle("r2_io_wr", 20'h0FF0A, 1'b1, 1'b0, 4'b0100, 1, 1'b0);
        bus_cycle("r3_io_wr", 20'h01DFF, 1'b1, 1'b0, 4'b1000, 15, 1'b0);
        bus_cycle("unmapped_1e00", 20'h01E00, 1'b1, 1'b1, 4'b0000, TO_N, TO_ERR);
        ALE = 1'b1; IOM = 1'b1; A = 12'h01D; AD = 8'hFF;
        @(posedge CLK); #1;
        ALE = 1'b0; WR = 1'b0;
        repeat (5) @(posedge CLK);
        #1 RESET = 1'b1;
        #1 snap("mid_reset", 20'h0, 4'b0000, 1'b1);
        @(posedge CLK); #1;
        RESET = 1'b0; WR = 1'b1;
        @(posedge CLK); #1;
        bus_cycle("r1_after_rst", 20'h80010, 1'b0, 1'b1, 4'b0010, 2, 1'b0);
        bus_cycle("timeout_0100", 20'h00100, 1'b1, 1'b1, 4'b0000, TO_N, TO_ERR);
        repeat (3) @(posedge CLK);
        #1 fin = 1'b1;
        #1 $finish;
    end

endmodule
